// File: rtl/lane_pkg.sv
// Shared lane identifiers, bus width and arbiter FSM states.
package lane_pkg;

  localparam logic [1:0] SRC_SMALL = 2'd0;
  localparam logic [1:0] SRC_QUAD  = 2'd1;
  localparam logic [1:0] SRC_WIDE  = 2'd2;
  localparam int unsigned BUS_W    = 70;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first requester at ptr, ptr+1, ptr+2 (mod 3).
module rr_pick3
  import lane_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = ptr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
      idx = inc_mod3(idx);
    end
  end

endmodule

// File: rtl/lane_arbiter.sv
// Round-robin arbiter sharing one 70-bit bus between the small, quad and wide lanes,
// with bounded bursts per grant and a sticky passed flag after PASS_COUNT beats.
module lane_arbiter
  import lane_pkg::*;
#(
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned PASS_COUNT = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             small_valid,
  output logic             small_ready,
  input  logic [1:0]       small_data,
  input  logic             quad_valid,
  output logic             quad_ready,
  input  logic [39:0]      quad_data,
  input  logic             wide_valid,
  output logic             wide_ready,
  input  logic [69:0]      wide_data,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic             passed
);

  localparam logic [3:0]  BURST_LIM = 4'(BURST_MAX);
  localparam logic [15:0] PASS_LIM  = 16'(PASS_COUNT);

  state_t      state, state_nx;
  logic [1:0]  gnt, gnt_nx;
  logic [1:0]  rr_ptr, rr_ptr_nx;
  logic [3:0]  beat_cnt, beat_cnt_nx;
  logic [15:0] xfer_cnt, xfer_cnt_nx;
  logic        passed_nx;
  logic [2:0]  req;
  logic [1:0]  pick;
  logic        pick_any;
  logic        gnt_valid;
  logic        beat;

  assign req = {wide_valid, quad_valid, small_valid};

  rr_pick3 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .win (pick),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      gnt      <= SRC_SMALL;
      rr_ptr   <= SRC_SMALL;
      beat_cnt <= '0;
      xfer_cnt <= '0;
      passed   <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      xfer_cnt <= xfer_cnt_nx;
      passed   <= passed_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    xfer_cnt_nx = xfer_cnt;
    passed_nx   = passed;
    out_valid   = 1'b0;
    out_data    = '0;
    out_src     = SRC_SMALL;
    small_ready = 1'b0;
    quad_ready  = 1'b0;
    wide_ready  = 1'b0;
    gnt_valid   = 1'b0;
    beat        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nx      = pick;
          beat_cnt_nx = '0;
          state_nx    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        out_src = gnt;
        case (gnt)
          SRC_QUAD: begin
            gnt_valid  = quad_valid;
            out_data   = {30'b0, quad_data};
            quad_ready = out_ready;
          end
          SRC_WIDE: begin
            gnt_valid  = wide_valid;
            out_data   = wide_data;
            wide_ready = out_ready;
          end
          default: begin
            gnt_valid   = small_valid;
            out_data    = {68'b0, small_data};
            small_ready = out_ready;
          end
        endcase
        out_valid = gnt_valid;
        beat      = gnt_valid & out_ready;

        if (beat) begin
          beat_cnt_nx = beat_cnt + 4'd1;
          if (xfer_cnt != PASS_LIM)
            xfer_cnt_nx = xfer_cnt + 16'd1;
          if (xfer_cnt_nx == PASS_LIM)
            passed_nx = 1'b1;
        end

        // A stalled beat (out_ready low) neither counts nor ends the burst.
        if (!gnt_valid || (beat && beat_cnt_nx == BURST_LIM)) begin
          state_nx  = ST_IDLE;
          rr_ptr_nx = inc_mod3(gnt);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_lane_arbiter;
  import lane_pkg::*;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        small_valid = 1'b0, quad_valid = 1'b0, wide_valid = 1'b0;
  logic        small_ready, quad_ready, wide_ready;
  logic [1:0]  small_data = '0;
  logic [39:0] quad_data = '0;
  logic [69:0] wide_data = '0;
  logic        out_valid;
  logic [69:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready = 1'b0;
  logic        passed;

  always #5 clk = ~clk;

  lane_arbiter #(.BURST_MAX(4), .PASS_COUNT(16)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .small_valid (small_valid),
    .small_ready (small_ready),
    .small_data  (small_data),
    .quad_valid  (quad_valid),
    .quad_ready  (quad_ready),
    .quad_data   (quad_data),
    .wide_valid  (wide_valid),
    .wide_ready  (wide_ready),
    .wide_data   (wide_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .passed      (passed)
  );

  localparam logic [1:0]  SD = 2'b10;
  localparam logic [39:0] QD = 40'hA5_0000_0001;
  localparam logic [69:0] WD = 70'h3F_0123_4567_89AB_CDEF;
  localparam logic [69:0] XS = 70'h2;
  localparam logic [69:0] XQ = 70'h00_0000_00A5_0000_0001;

  typedef struct {
    logic        rst;
    logic        sv, qv, wv;
    logic        ov;
    logic [69:0] od;
    logic [1:0]  src;
    logic [2:0]  rdy;   // {wide, quad, small}
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t row(input logic rst, input logic sv, input logic qv, input logic wv,
                               input logic ov, input logic [69:0] od, input logic [1:0] src,
                               input logic [2:0] rdy);
    vec_t v;
    v.rst = rst; v.sv = sv; v.qv = qv; v.wv = wv;
    v.ov = ov; v.od = od; v.src = src; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ov, input logic [69:0] od,
                         input logic [1:0] src, input logic [2:0] rdy, input logic pass);
    chk({name, ".valid"}, 70'(out_valid), 70'(ov));
    chk({name, ".data"}, out_data, od);
    chk({name, ".src"}, 70'(out_src), 70'(src));
    chk({name, ".ready"}, 70'({wide_ready, quad_ready, small_ready}), 70'(rdy));
    chk({name, ".passed"}, 70'(passed), 70'(pass));
  endtask

  task automatic cyc(input string name, input logic ov, input logic [69:0] od,
                     input logic [1:0] src, input logic [2:0] rdy);
    @(negedge clk);
    chk_out(name, ov, od, src, rdy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    small_valid = 1'b0; quad_valid = 1'b0; wide_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_l = 1'b1;
  endtask

  initial begin
    logic [69:0] xd [3];
    xd[0] = XS; xd[1] = XQ; xd[2] = WD;
    small_data = SD; quad_data = QD; wide_data = WD;

    // Single quad lane: 4 beats, one bubble, repeat.
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(row(r == 0, 0, 1, 0, 0, '0, SRC_SMALL, 3'b000));
      for (int b = 0; b < 4; b++)
        vecs.push_back(row(0, 0, 1, 0, 1, XQ, SRC_QUAD, 3'b010));
    end
    vecs.push_back(row(0, 0, 1, 0, 0, '0, SRC_SMALL, 3'b000));
    // All lanes valid: small, quad, wide, small.
    vecs.push_back(row(1, 1, 1, 1, 0, '0, SRC_SMALL, 3'b000));
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 4; b++)
        vecs.push_back(row(0, 1, 1, 1, 1, xd[l], 2'(l), 3'b001 << l));
      vecs.push_back(row(0, 1, 1, 1, 0, '0, SRC_SMALL, 3'b000));
    end
    vecs.push_back(row(0, 1, 1, 1, 1, XS, SRC_SMALL, 3'b001));

    // Reset state with every lane requesting.
    reset_l = 1'b0;
    small_valid = 1'b1; quad_valid = 1'b1; wide_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk_out("reset0", 1'b0, '0, SRC_SMALL, 3'b000, 1'b0);
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      small_valid = vecs[i].sv; quad_valid = vecs[i].qv; wide_valid = vecs[i].wv;
      out_ready = 1'b1;
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].src, vecs[i].rdy, 1'b0);
      @(posedge clk); #1;
    end

    // Backpressure mid-burst: grant and data held, burst still 4 beats.
    do_reset();
    quad_valid = 1'b1;
    cyc("bp.idle", 0, '0, SRC_SMALL, 3'b000);
    cyc("bp.b1", 1, XQ, SRC_QUAD, 3'b010);
    cyc("bp.b2", 1, XQ, SRC_QUAD, 3'b010);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) cyc($sformatf("bp.stall%0d", s), 1, XQ, SRC_QUAD, 3'b000);
    out_ready = 1'b1;
    cyc("bp.b3", 1, XQ, SRC_QUAD, 3'b010);
    cyc("bp.b4", 1, XQ, SRC_QUAD, 3'b010);
    cyc("bp.bubble", 0, '0, SRC_SMALL, 3'b000);

    // Early drop of wide after 2 beats: pointer must move back to small.
    do_reset();
    quad_valid = 1'b1;
    cyc("ed.idle0", 0, '0, SRC_SMALL, 3'b000);
    for (int b = 0; b < 4; b++) cyc($sformatf("ed.q%0d", b), 1, XQ, SRC_QUAD, 3'b010);
    quad_valid = 1'b0; wide_valid = 1'b1;
    cyc("ed.idle1", 0, '0, SRC_SMALL, 3'b000);
    cyc("ed.w1", 1, WD, SRC_WIDE, 3'b100);
    cyc("ed.w2", 1, WD, SRC_WIDE, 3'b100);
    wide_valid = 1'b0;
    @(negedge clk);
    chk("ed.drop.valid", 70'(out_valid), 70'(1'b0));
    @(posedge clk); #1;
    small_valid = 1'b1; quad_valid = 1'b1; wide_valid = 1'b1;
    cyc("ed.idle2", 0, '0, SRC_SMALL, 3'b000);
    cyc("ed.small", 1, XS, SRC_SMALL, 3'b001);

    // Pass flag after 16 beats, sticky, then async reset mid-burst.
    do_reset();
    small_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("pass.c%0d.valid", c), 70'(out_valid), 70'(c % 5 != 0));
      chk($sformatf("pass.c%0d.passed", c), 70'(passed), 70'(1'b0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pass.set", 70'(passed), 70'(1'b1));
    repeat (101) @(posedge clk);
    @(negedge clk);
    chk("pass.sticky", 70'(passed), 70'(1'b1));
    chk("pass.midburst.valid", 70'(out_valid), 70'(1'b1));
    reset_l = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, '0, SRC_SMALL, 3'b000, 1'b0);
    @(posedge clk); #1;
    reset_l = 1'b1;
    quad_valid = 1'b1;
    cyc("rst.idle", 0, '0, SRC_SMALL, 3'b000);
    cyc("rst.small", 1, XS, SRC_SMALL, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
